// File: rtl/piso_bit_serializer_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector:
// state encodings, detector state values and a constant-width helper.
package piso_bit_serializer_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Detector (1011 pattern) state values, kept here so both stages agree.
  localparam logic [2:0] DET_S0    = 3'd0;
  localparam logic [2:0] DET_S1    = 3'd1;
  localparam logic [2:0] DET_S10   = 3'd2;
  localparam logic [2:0] DET_S101  = 3'd3;
  localparam logic [2:0] DET_S1011 = 3'd4;

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int unsigned ser_clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd31; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Parallel-in / serial-out bundle: word handshake, bit strobe and serial outputs.
interface piso_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output in_data, in_valid, bit_en,
    input  in_ready, ser_out, ser_valid, frame_start, busy
  );

  modport slave (
    input  in_data, in_valid, bit_en,
    output in_ready, ser_out, ser_valid, frame_start, busy
  );
endinterface

// File: rtl/piso_bit_serializer_word_hold_buf.sv
// One-entry word buffer: accepts on valid & ready, empties on the load strobe.
module piso_bit_serializer_word_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             load_i,
  output logic [WIDTH-1:0] hold_data_o,
  output logic             hold_full_o
);

  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic             accept_s;

  assign accept_s = in_valid_i & ~hold_full_q;

  // Load only happens when full and accept only when empty, so they never collide.
  always_comb begin
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    if (load_i) begin
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hold_data_d = in_data_i;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign in_ready_o  = ~hold_full_q;
  assign hold_data_o = hold_data_q;
  assign hold_full_o = hold_full_q;

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector; one bit per bit_en strobe,
// with a one-word holding buffer so consecutive words stream without a gap.
module piso_bit_serializer
  import piso_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  piso_bit_serializer_if.slave   bus
);

  localparam int unsigned    CNT_W    = ser_clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;

  logic [WIDTH-1:0] hold_data_s;
  logic             hold_full_s;
  logic             load_s;
  logic             last_bit_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // sr always holds the bits not yet emitted, aligned so first_bit() picks the next one.
  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  piso_bit_serializer_word_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (bus.in_data),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .load_i      (load_s),
    .hold_data_o (hold_data_s),
    .hold_full_o (hold_full_s)
  );

  assign last_bit_s = (cnt_q == CNT_LAST);
  assign load_s     = bus.bit_en & hold_full_s & ((state_q == SER_IDLE) | last_bit_s);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= SER_IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      ser_out_q     <= IDLE_BIT;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      SER_IDLE: begin
        if (load_s) begin
          state_d = SER_SHIFT;
          sr_d    = drop_bit(hold_data_s);
          cnt_d   = '0;
        end else begin
          state_d = SER_IDLE;
        end
      end
      SER_SHIFT: begin
        if (!bus.bit_en) begin
          state_d = SER_SHIFT;
        end else if (!last_bit_s) begin
          sr_d  = drop_bit(sr_q);
          cnt_d = cnt_q + CNT_W'(1);
        end else if (hold_full_s) begin
          sr_d  = drop_bit(hold_data_s);
          cnt_d = '0;
        end else begin
          state_d = SER_IDLE;
        end
      end
      default: begin
        state_d = SER_IDLE;
      end
    endcase
  end

  always_comb begin
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = load_s;
    if (load_s) begin
      ser_out_d   = first_bit(hold_data_s);
      ser_valid_d = 1'b1;
    end else if ((state_q == SER_SHIFT) && bus.bit_en) begin
      if (!last_bit_s) begin
        ser_out_d   = first_bit(sr_q);
        ser_valid_d = 1'b1;
      end else begin
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
      end
    end else begin
      ser_out_d   = ser_out_q;
      ser_valid_d = ser_valid_q;
    end
  end

  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state_q == SER_SHIFT) | hold_full_s;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench: MSB-first/idle-0 instance for most cases, LSB-first/idle-1 for the last.
module tb_piso_bit_serializer;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piso_bit_serializer_if #(.WIDTH(8)) bus0 ();
  piso_bit_serializer_if #(.WIDTH(8)) bus1 ();

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic so, sv, fs, ir, bz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grab(input int sel);
    if (sel == 0) begin
      so = bus0.ser_out; sv = bus0.ser_valid; fs = bus0.frame_start;
      ir = bus0.in_ready; bz = bus0.busy;
    end else begin
      so = bus1.ser_out; sv = bus1.ser_valid; fs = bus1.frame_start;
      ir = bus1.in_ready; bz = bus1.busy;
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      bus0.in_valid = v; bus0.in_data = d;
    end else begin
      bus1.in_valid = v; bus1.in_data = d;
    end
  endtask

  // One word with bit_en held high; exp lists the bits in send order, MSB of exp first.
  task automatic single_word(input int sel, input logic [7:0] w, input logic [7:0] exp,
                             input logic idle_lvl, input string tag);
    grab(sel);
    chk({tag, "_rdy_pre"}, 16'(ir), 16'd1);
    drive(sel, 1'b1, w);
    tick();
    drive(sel, 1'b0, 8'h00);
    grab(sel);
    chk({tag, "_rdy_held"}, 16'(ir), 16'd0);
    chk({tag, "_lat_valid"}, 16'(sv), 16'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      grab(sel);
      chk($sformatf("%s_bit%0d", tag, i), 16'(so), 16'(exp[7-i]));
      chk($sformatf("%s_vld%0d", tag, i), 16'(sv), 16'd1);
      chk($sformatf("%s_fs%0d", tag, i), 16'(fs), (i == 0) ? 16'd1 : 16'd0);
    end
    tick();
    grab(sel);
    chk({tag, "_end_valid"}, 16'(sv), 16'd0);
    chk({tag, "_end_idle"}, 16'(so), 16'(idle_lvl));
    chk({tag, "_end_busy"}, 16'(bz), 16'd0);
  endtask

  logic [15:0] bits_v, fs_v, vld_v;
  int          fs_cnt, vld_cnt;
  logic [7:0]  t4_w;

  initial begin
    // T1: reset held with in_valid asserted
    rst = 1'b0;
    drive(0, 1'b1, 8'hFF);
    drive(1, 1'b0, 8'h00);
    bus0.bit_en = 1'b1;
    bus1.bit_en = 1'b1;
    tick();
    tick();
    grab(0);
    chk("t1_valid", 16'(sv), 16'd0);
    chk("t1_out", 16'(so), 16'd0);
    chk("t1_ready", 16'(ir), 16'd1);
    chk("t1_busy", 16'(bz), 16'd0);
    chk("t1_fs", 16'(fs), 16'd0);
    grab(1);
    chk("t1_idle_hi", 16'(so), 16'd1);
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    tick();
    grab(0);
    chk("t1_nocap_busy", 16'(bz), 16'd0);
    chk("t1_nocap_valid", 16'(sv), 16'd0);

    // T2: single word, MSB first
    single_word(0, 8'hB0, 8'hB0, 1'b0, "t2");

    // T3: back-to-back words stream contiguously
    drive(0, 1'b1, 8'hA5);
    tick();
    drive(0, 1'b1, 8'h3C);
    for (int i = 0; i < 16; i++) begin
      tick();
      grab(0);
      bits_v[15-i] = so;
      fs_v[15-i]   = fs;
      vld_v[15-i]  = sv;
      if (i == 1) begin
        chk("t3_ready_held", 16'(ir), 16'd0);
        drive(0, 1'b0, 8'h00);
      end
    end
    chk("t3_bits", bits_v, 16'hA53C);
    chk("t3_frames", fs_v, 16'h8080);
    chk("t3_valids", vld_v, 16'hFFFF);
    tick();
    grab(0);
    chk("t3_end_valid", 16'(sv), 16'd0);

    // T4: bit_en one cycle in four
    t4_w = 8'hC3;
    bus0.bit_en = 1'b0;
    drive(0, 1'b1, t4_w);
    tick();
    drive(0, 1'b0, 8'h00);
    fs_cnt  = 0;
    vld_cnt = 0;
    for (int c = 0; c < 36; c++) begin
      bus0.bit_en = ((c % 4) == 0);
      tick();
      grab(0);
      if (fs) fs_cnt++;
      if (sv) vld_cnt++;
      if (c < 32) begin
        chk($sformatf("t4_bit_c%0d", c), 16'(so), 16'(t4_w[7 - (c / 4)]));
      end else begin
        chk($sformatf("t4_idle_c%0d", c), 16'(so), 16'd0);
      end
      chk($sformatf("t4_fs_c%0d", c), 16'(fs), (c == 0) ? 16'd1 : 16'd0);
    end
    chk("t4_fs_count", 16'(fs_cnt), 16'd1);
    chk("t4_valid_cycles", 16'(vld_cnt), 16'd32);
    bus0.bit_en = 1'b1;

    // T5: reset mid-word with a word held, then a fresh word
    drive(0, 1'b1, 8'hFF);
    tick();
    drive(0, 1'b1, 8'h0F);
    tick();
    tick();
    drive(0, 1'b0, 8'h00);
    tick();
    grab(0);
    chk("t5_pre_busy", 16'(bz), 16'd1);
    chk("t5_pre_ready", 16'(ir), 16'd0);
    chk("t5_pre_bit", 16'(so), 16'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    grab(0);
    chk("t5_rst_valid", 16'(sv), 16'd0);
    chk("t5_rst_ready", 16'(ir), 16'd1);
    chk("t5_rst_busy", 16'(bz), 16'd0);
    chk("t5_rst_out", 16'(so), 16'd0);
    tick();
    tick();
    grab(0);
    chk("t5_no_flush", 16'(sv), 16'd0);
    single_word(0, 8'h81, 8'h81, 1'b0, "t5");

    // T6: LSB first, idle level high; 8'h0D sends 1,0,1,1,0,0,0,0
    single_word(1, 8'h0D, 8'b1011_0000, 1'b1, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
